// File: rtl/alu_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_arb_pkg
// Description : Shared widths, ALU opcode constants and arbiter FSM state type
// Revision    : 1.0 - initial release
// ============================================================================
package alu_arb_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int OP_W_DEF   = 4;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRL = 4'b0101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin grant. ptr=0 favours requester 0,
//               ptr=1 favours requester 1; a lone valid always wins.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic valid0,
    input  logic valid1,
    input  logic ptr,
    output logic grant0,
    output logic grant1
);

    // Grant the favoured requester on contention, otherwise whoever is valid
    always_comb begin
        grant0 = valid0 & (~valid1 | ~ptr);
        grant1 = valid1 & (~valid0 |  ptr);
    end

endmodule
`default_nettype wire

// File: rtl/alu_arb2.sv
`default_nettype none
// ============================================================================
// Module      : alu_arb2
// Description : Shares one external combinational ALU between two requesters.
//               IDLE -> EXEC -> RESP, one transaction in flight at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arb2
    import alu_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int OP_W   = OP_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_op,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_data,
    input  logic              rsp0_ready,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_data,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_result
);

    state_t            r_state;
    state_t            w_next;
    logic              r_ptr;
    logic              r_id;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [OP_W-1:0]   r_op;
    logic [DATA_W-1:0] r_res;
    logic              w_grant0;
    logic              w_grant1;
    logic              w_accept;
    logic              w_rsp_hs;

    rr_arb2 u_rr_arb2 (
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .ptr    (r_ptr),
        .grant0 (w_grant0),
        .grant1 (w_grant1)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode plus handshake outputs; reset forces every handshake low
    always_comb begin
        w_next     = r_state;
        w_accept   = 1'b0;
        w_rsp_hs   = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req0_ready = w_grant0;
                req1_ready = w_grant1;
                if (w_grant0 || w_grant1) begin
                    w_accept = 1'b1;
                    w_next   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_next = ST_RESP;
            end
            ST_RESP: begin
                rsp0_valid = ~r_id;
                rsp1_valid =  r_id;
                w_rsp_hs   = r_id ? rsp1_ready : rsp0_ready;
                if (w_rsp_hs) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
        if (rst) begin
            w_accept   = 1'b0;
            w_rsp_hs   = 1'b0;
            req0_ready = 1'b0;
            req1_ready = 1'b0;
            rsp0_valid = 1'b0;
            rsp1_valid = 1'b0;
        end
    end

    // Payload capture on accept, result capture in EXEC, pointer flip on response handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= 1'b0;
            r_id  <= 1'b0;
            r_a   <= '0;
            r_b   <= '0;
            r_op  <= '0;
            r_res <= '0;
        end else begin
            if (w_accept) begin
                r_id <= w_grant1;
                r_a  <= w_grant1 ? req1_a  : req0_a;
                r_b  <= w_grant1 ? req1_b  : req0_b;
                r_op <= w_grant1 ? req1_op : req0_op;
            end
            if (r_state == ST_EXEC) begin
                r_res <= alu_result;
            end
            if (w_rsp_hs) begin
                r_ptr <= ~r_id;
            end
        end
    end

    // ALU operands come only from the captured registers; held at zero during reset
    always_comb begin
        alu_a  = rst ? '0 : r_a;
        alu_b  = rst ? '0 : r_b;
        alu_op = rst ? '0 : r_op;
    end

    // Both response ports share the single result register
    always_comb begin
        rsp0_data = r_res;
        rsp1_data = r_res;
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_arb2.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arb2
// Description : Self-checking bench for alu_arb2 with a behavioural shared ALU
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arb2;
    import alu_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [3:0]  req0_op = '0, req1_op = '0;
    logic        rsp0_valid, rsp1_valid;
    logic [15:0] rsp0_data, rsp1_data;
    logic        rsp0_ready = 1'b1, rsp1_ready = 1'b1;
    logic [15:0] alu_a, alu_b, alu_result;
    logic [3:0]  alu_op;

    typedef struct packed {
        logic        id;
        logic [15:0] data;
    } exp_t;

    typedef struct {
        logic        id;
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp;
    } vec_t;

    exp_t sb[$];
    int   grant_log[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t mon_e;
    vec_t vecs[9];

    always #5 clk = ~clk;

    alu_arb2 #(.DATA_W(16), .OP_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .rsp0_valid (rsp0_valid),
        .rsp0_data  (rsp0_data),
        .rsp0_ready (rsp0_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_data  (rsp1_data),
        .rsp1_ready (rsp1_ready),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result)
    );

    // Shared ALU model living outside the arbiter
    always_comb begin
        case (alu_op)
            OP_ADD:  alu_result = alu_a + alu_b;
            OP_SUB:  alu_result = alu_a - alu_b;
            OP_AND:  alu_result = alu_a & alu_b;
            OP_OR:   alu_result = alu_a | alu_b;
            OP_SLL:  alu_result = alu_a << alu_b[3:0];
            OP_SRL:  alu_result = alu_a >> alu_b[3:0];
            default: alu_result = 16'h0000;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Response monitor: pops the scoreboard on every response handshake
    always @(negedge clk) begin
        if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_rsp: got rsp0_valid=%0b rsp1_valid=%0b expected none", rsp0_valid, rsp1_valid);
            end else begin
                mon_e = sb.pop_front();
                check("rsp_valid_vec", {30'd0, rsp1_valid, rsp0_valid}, mon_e.id ? 32'd2 : 32'd1);
                check("rsp_data", mon_e.id ? rsp1_data : rsp0_data, mon_e.data);
            end
        end
    end

    task automatic issue(input logic id, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] exp);
        bit   done = 0;
        exp_t e;
        @(posedge clk); #1;
        if (id == 1'b0) begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if ((id == 1'b0 && req0_ready) || (id == 1'b1 && req1_ready)) begin
                e.id   = id;
                e.data = exp;
                sb.push_back(e);
                grant_log.push_back(int'(id));
                done = 1;
            end
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL issue_timeout: got no ready for req%0d expected accept", id);
        end
        @(posedge clk); #1;
        if (id == 1'b0) req0_valid = 1'b0;
        else            req1_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, OP_ADD, 16'h0003, 16'h0004, 16'h0007};
        vecs[1] = '{1'b1, OP_SUB, 16'h0010, 16'h0001, 16'h000F};
        vecs[2] = '{1'b0, OP_AND, 16'h00FF, 16'h0F0F, 16'h000F};
        vecs[3] = '{1'b1, OP_OR,  16'h00F0, 16'h000F, 16'h00FF};
        vecs[4] = '{1'b0, OP_SLL, 16'h0001, 16'h000F, 16'h8000};
        vecs[5] = '{1'b1, OP_SRL, 16'h8000, 16'h0004, 16'h0800};
        vecs[6] = '{1'b0, 4'b0111, 16'hFFFF, 16'hFFFF, 16'h0000};
        vecs[7] = '{1'b1, OP_SUB, 16'h0000, 16'h0001, 16'hFFFF};
        vecs[8] = '{1'b0, OP_ADD, 16'hFFFF, 16'h0001, 16'h0000};

        // Reset with both requesters asserting: nothing may be granted
        req0_valid = 1'b1; req0_a = 16'h1234; req0_b = 16'h5678; req0_op = OP_OR;
        req1_valid = 1'b1; req1_a = 16'h4321; req1_b = 16'h8765; req1_op = OP_SUB;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req0_ready", req0_ready, 0);
        check("rst_req1_ready", req1_ready, 0);
        check("rst_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_alu_op", alu_op, 0);
        @(posedge clk); #1;
        rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;

        // First transaction with latency checks
        issue(1'b0, OP_ADD, 16'h0003, 16'h0004, 16'h0007);
        @(negedge clk);
        check("lat_exec_rsp0_valid", rsp0_valid, 0);
        check("exec_alu_a", alu_a, 16'h0003);
        check("exec_alu_b", alu_b, 16'h0004);
        @(negedge clk);
        check("lat_resp_rsp0_valid", rsp0_valid, 1);
        wait_drain();

        // Table-driven vectors, one at a time
        for (int v = 0; v < 9; v++) begin
            issue(vecs[v].id, vecs[v].op, vecs[v].a, vecs[v].b, vecs[v].exp);
            wait_drain();
        end

        // Contention: pointer back to requester 0, grants must alternate
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        grant_log.delete();
        fork
            begin
                issue(1'b0, OP_SUB, 16'h0010, 16'h0001, 16'h000F);
                issue(1'b0, OP_SUB, 16'h0010, 16'h0001, 16'h000F);
            end
            begin
                issue(1'b1, OP_OR, 16'h00F0, 16'h000F, 16'h00FF);
                issue(1'b1, OP_OR, 16'h00F0, 16'h000F, 16'h00FF);
            end
        join
        wait_drain();
        check("rr_count", grant_log.size(), 4);
        if (grant_log.size() == 4) begin
            check("rr_grant0", grant_log[0], 0);
            check("rr_grant1", grant_log[1], 1);
            check("rr_grant2", grant_log[2], 0);
            check("rr_grant3", grant_log[3], 1);
        end

        // Back-pressure on requester 1 while requester 0 waits
        @(posedge clk); #1 rsp1_ready = 1'b0;
        issue(1'b1, OP_SLL, 16'h0001, 16'h000F, 16'h8000);
        for (int i = 0; i < 10 && !rsp1_valid; i++) @(negedge clk);
        req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 16'h0003; req0_b = 16'h0004;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_rsp1_valid", rsp1_valid, 1);
            check("stall_rsp1_data", rsp1_data, 16'h8000);
            check("stall_ready", {req1_ready, req0_ready}, 0);
        end
        @(posedge clk); #1 rsp1_ready = 1'b1;
        issue(1'b0, OP_ADD, 16'h0003, 16'h0004, 16'h0007);
        wait_drain();

        // Reset during EXEC drops the transaction and re-favours requester 0
        issue(1'b0, OP_AND, 16'h00FF, 16'h0F0F, 16'h000F);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_alu_a", alu_a, 0);
        check("midrst_alu_op", alu_op, 0);
        @(posedge clk); #1 rst = 1'b0;
        sb.delete();
        grant_log.delete();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("dropped_rsp0_valid", rsp0_valid, 0);
        end
        fork
            issue(1'b0, OP_ADD, 16'h0010, 16'h0020, 16'h0030);
            issue(1'b1, OP_ADD, 16'h0001, 16'h0001, 16'h0002);
        join
        wait_drain();
        check("postrst_first_grant", grant_log.size() > 0 ? grant_log[0] : 99, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_arb2.md
ALU_ARB2 -- requirements
Module: alu_arb2

Interface
REQ-001 Parameter DATA_W, default 16, operand/result width; SHALL match the shared ALU width.
REQ-002 Parameter OP_W, default 4, opcode width.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset; synchronous and active-high.
REQ-005 reqN_valid  in  1  (N=0,1) requester N presents an operation.
REQ-006 reqN_ready  out  1  operation from requester N accepted this cycle when reqN_valid also high.
REQ-007 reqN_a, reqN_b  in  DATA_W  operands A and B from requester N.
REQ-008 reqN_op  in  OP_W  opcode from requester N.
REQ-009 rspN_valid  out  1  result for requester N available.
REQ-010 rspN_data  out  DATA_W  result for requester N.
REQ-011 rspN_ready  in  1  requester N consumes response when rspN_valid also high.
REQ-012 alu_a, alu_b  out  DATA_W  operands driven to the shared ALU.
REQ-013 alu_op  out  OP_W  opcode driven to the shared ALU.
REQ-014 alu_result  in  DATA_W  combinational result returned by the shared ALU.

Function
REQ-015 FSM states: IDLE, EXEC, RESP; exactly one active.
REQ-016 IDLE: if any reqN_valid, grant one requester per round-robin pointer; assert only that reqN_ready (combinational from state, valids, pointer); go to EXEC on the accept edge.
REQ-017 Round-robin: with both valid, grant the requester not served last; with one valid, grant it regardless of pointer.
REQ-018 Accept edge: register reqN_a, reqN_b, reqN_op and grant id; alu_a/alu_b/alu_op driven only from these registers.
REQ-019 EXEC: one cycle; capture alu_result into response register; go to RESP.
REQ-020 RESP: assert rspN_valid for the granted id only; rspN_data holds the captured result, stable until handshake.
REQ-021 RESP with rspN_ready high: deassert rspN_valid next cycle, set pointer to favour the other requester, go to IDLE.
REQ-022 RESP with rspN_ready low: remain in RESP indefinitely, outputs unchanged.
REQ-023 Both reqN_ready SHALL be low in EXEC and RESP; new requests wait.
REQ-024 Latency: accept at edge T -> rspN_valid high in cycle T+2; minimum issue interval 3 cycles.
REQ-025 Opcodes 0110-1111 forwarded unchanged; response carries whatever alu_result returns (0); no error signalling.
REQ-026 rsp1_data SHALL equal rsp0_data source register; non-granted rspN_valid stays 0.
REQ-027 Requesters SHALL hold valid and payload stable until ready; the block does not check this.

Reset
REQ-028 rst high: state -> IDLE, pointer favours requester 0, operand/opcode registers -> 0, response register -> 0, id -> 0.
REQ-029 While rst high: reqN_ready = 0, rspN_valid = 0, alu_a = alu_b = 0, alu_op = 0.
REQ-030 Reset mid-operation (EXEC or RESP) drops the transaction; no response is later produced.

Structure
REQ-031 Package alu_arb_pkg: DATA_W/OP_W defaults, opcode constants ADD=0000, SUB=0001, AND=0010, OR=0011, SLL=0100, SRL=0101, FSM state type.
REQ-032 One sub-module rr_arb2: 2-way round-robin grant from two valids and pointer; pointer update stays in alu_arb2.
REQ-033 Shared ALU instantiated outside alu_arb2; only alu_a/alu_b/alu_op/alu_result cross the boundary.

Verification
REQ-034 After reset, req0 ADD A=0x0003 B=0x0004 -> req0_ready at accept, rsp0_valid 2 cycles later, rsp0_data=0x0007.
REQ-035 Both valid every cycle, req0 SUB 0x0010-0x0001, req1 OR 0x00F0|0x000F -> grants alternate 0,1,0,1; rsp0_data=0x000F, rsp1_data=0x00FF.
REQ-036 req1 SLL A=0x0001 B=0x000F, rsp1_ready held low 5 cycles -> rsp1_valid/rsp1_data=0x8000 stable 5 cycles, both reqN_ready low throughout.
REQ-037 req0 opcode 0111 A=0xFFFF B=0xFFFF -> rsp0_data=0x0000, FSM returns to IDLE normally.
REQ-038 rst pulsed in EXEC of req0 AND 0x00FF&0x0F0F -> no rsp0_valid ever; next request granted to requester 0 when both valid.
